// File: rtl/gsim_pkg.sv
// gsim_pkg: shared widths, band coefficients and FSM states for the Gauss-Seidel host
package gsim_pkg;
    localparam int N  = 16;
    localparam int BW = 16;
    localparam int XW = 32;
    localparam int RW = 42;

    localparam logic signed [7:0] A_DIAG = 8'sd20;
    localparam logic signed [7:0] A_OFF1 = -8'sd13;
    localparam logic signed [7:0] A_OFF2 = 8'sd6;
    localparam logic signed [7:0] A_OFF3 = -8'sd1;

    typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, DONE} state_t;

    function automatic logic signed [7:0] band_coef(input int d);
        return d == 0 ? A_DIAG :
               (d == 1 || d == -1) ? A_OFF1 :
               (d == 2 || d == -2) ? A_OFF2 : A_OFF3;
    endfunction
endpackage

// File: rtl/gsim_band_row.sv
// gsim_band_row: residual of one row of the 7-wide banded system, out-of-range taps masked off
module gsim_band_row
    import gsim_pkg::*;
(
    input  logic signed [XW-1:0] x_win [7],
    input  logic        [6:0]    mask,
    input  logic signed [BW-1:0] b_i,
    output logic signed [RW-1:0] r
);
    always_comb begin
        r = -(RW'(b_i) <<< 16);
        for (int k = 0; k < 7; k++)
            r = mask[k] ? r + RW'(band_coef(k - 3)) * RW'(x_win[k]) : r;
    end
endmodule

// File: rtl/gsim_host.sv
// gsim_host: streams b to the solver, captures x, and checks the worst residual of A*x - b
module gsim_host
    import gsim_pkg::*;
#(
    parameter int TOL     = 1024,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          b_wr_en,
    input  logic [3:0]    b_wr_addr,
    input  logic [BW-1:0] b_wr_data,
    output logic          solver_in_en,
    output logic [BW-1:0] solver_b,
    input  logic          solver_out_valid,
    input  logic [XW-1:0] solver_x,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [RW-1:0] max_err,
    input  logic [3:0]    x_rd_addr,
    output logic [XW-1:0] x_rd_data
);
    localparam int WCW = $clog2(TIMEOUT + 1);

    state_t                state_q, state_d;
    logic signed [BW-1:0]  b_mem_q [N];
    logic signed [BW-1:0]  b_mem_d [N];
    logic [XW-1:0]         x_mem_q [N];
    logic [XW-1:0]         x_mem_d [N];
    logic [4:0]            k_q, k_d, idx_q, idx_d;
    logic [3:0]            row_q, row_d;
    logic [WCW-1:0]        wcnt_q, wcnt_d;
    logic                  in_en_q, in_en_d, busy_q, busy_d, done_q, done_d;
    logic                  pass_q, pass_d, timeout_q, timeout_d;
    logic [BW-1:0]         sb_q, sb_d;
    logic [RW-1:0]         max_err_q, max_err_d, abs_r, max_new;
    logic signed [XW-1:0]  x_win [7];
    logic [6:0]            mask;
    logic signed [RW-1:0]  r;

    // Negative column indices wrap to >= 29, so one unsigned compare covers both edges
    for (genvar g = 0; g < 7; g++) begin : g_win
        logic [4:0] j;
        assign j        = {1'b0, row_q} + 5'(g) - 5'd3;
        assign mask[g]  = j < 5'(N);
        assign x_win[g] = x_mem_q[j[3:0]];
    end

    gsim_band_row u_row (.x_win(x_win), .mask(mask), .b_i(b_mem_q[row_q]), .r(r));

    assign abs_r   = r[RW-1] ? -r : r;
    assign max_new = abs_r > max_err_q ? abs_r : max_err_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        idx_d     = idx_q;
        row_d     = row_q;
        wcnt_d    = wcnt_q;
        in_en_d   = 1'b0;
        sb_d      = '0;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        max_err_d = max_err_q;
        b_mem_d   = b_mem_q;
        x_mem_d   = x_mem_q;
        if (b_wr_en && !busy_q) b_mem_d[b_wr_addr] = b_wr_data;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d   = SEND;
                in_en_d   = 1'b1;
                sb_d      = b_mem_q[0];
                k_d       = 5'd1;
                idx_d     = '0;
                row_d     = '0;
                wcnt_d    = '0;
                done_d    = 1'b0;
                pass_d    = 1'b0;
                timeout_d = 1'b0;
                max_err_d = '0;
            end
            SEND: if (k_q == 5'(N)) state_d = WAIT;
            else begin
                in_en_d = 1'b1;
                sb_d    = b_mem_q[k_q[3:0]];
                k_d     = k_q + 5'd1;
            end
            WAIT: begin
                wcnt_d = wcnt_q + WCW'(1);
                if (solver_out_valid) begin
                    x_mem_d[idx_q[3:0]] = solver_x;
                    idx_d               = idx_q + 5'd1;
                end
                if (solver_out_valid && idx_q == 5'(N - 1)) state_d = CHECK;
                else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            CHECK: begin
                max_err_d = max_new;
                row_d     = row_q + 4'd1;
                if (row_q == 4'(N - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = max_new <= RW'(TOL);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d inside {SEND, WAIT, CHECK};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            idx_q     <= '0;
            row_q     <= '0;
            wcnt_q    <= '0;
            in_en_q   <= 1'b0;
            sb_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            max_err_q <= '0;
            for (int i = 0; i < N; i++) begin
                b_mem_q[i] <= '0;
                x_mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            wcnt_q    <= wcnt_d;
            in_en_q   <= in_en_d;
            sb_q      <= sb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            max_err_q <= max_err_d;
            b_mem_q   <= b_mem_d;
            x_mem_q   <= x_mem_d;
        end
    end

    assign solver_in_en = in_en_q;
    assign solver_b     = sb_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign max_err      = max_err_q;
    assign x_rd_data    = x_mem_q[x_rd_addr];
endmodule

// File: tb/tb_gsim_host.sv
// tb_gsim_host: scenario bench with a b-stream scoreboard and a residual reference model
module tb_gsim_host;
    localparam int N       = 16;
    localparam int TOL     = 1024;
    localparam int TIMEOUT = 4096;
    localparam int LAT     = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_addr = '0;
    logic [15:0] b_wr_data = '0;
    logic        solver_in_en;
    logic [15:0] solver_b;
    logic        solver_out_valid = 1'b0;
    logic [31:0] solver_x = '0;
    logic        busy, done, pass, timeout;
    logic [41:0] max_err;
    logic [3:0]  x_rd_addr = '0;
    logic [31:0] x_rd_data;

    int checks = 0;
    int errors = 0;
    logic [15:0]        exp_b [$];
    logic [15:0]        b_head;
    logic signed [15:0] b_ref  [N];
    logic signed [31:0] x_drv  [N];
    logic [31:0]        x_prev [N];
    int                 coef   [7] = '{-1, 6, -13, 20, -13, 6, -1};

    always #5 clk = ~clk;

    gsim_host #(.TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .solver_in_en(solver_in_en), .solver_b(solver_b),
        .solver_out_valid(solver_out_valid), .solver_x(solver_x),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .max_err(max_err),
        .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data)
    );

    // Every in_en beat must match the next b value queued when the run was launched
    always @(negedge clk) begin
        if (!reset && solver_in_en) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL stream: unexpected in_en beat b=%0h", solver_b);
            end else begin
                b_head = exp_b.pop_front();
                if (solver_b !== b_head) begin
                    errors++;
                    $display("FAIL stream: solver_b=%0h expected %0h", solver_b, b_head);
                end
            end
        end
    end

    function automatic longint model_max();
        longint m = 0;
        for (int i = 0; i < N; i++) begin
            longint acc = -longint'(b_ref[i]) * 65536;
            for (int j = i - 3; j <= i + 3; j++)
                if (j >= 0 && j < N) acc += longint'(coef[j - i + 3]) * longint'(x_drv[j]);
            if (acc < 0) acc = -acc;
            if (acc > m) m = acc;
        end
        return m;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_b(input int a, input int v);
        b_wr_en = 1'b1; b_wr_addr = 4'(a); b_wr_data = 16'(v);
        tick(1);
        b_wr_en = 1'b0;
        b_ref[a] = 16'(v);
    endtask

    task automatic load_ones();
        for (int i = 0; i < N; i++) begin
            int s = 0;
            for (int j = i - 3; j <= i + 3; j++)
                if (j >= 0 && j < N) s += coef[j - i + 3];
            write_b(i, s);
            x_drv[i] = 32'sh0001_0000;
        end
    endtask

    task automatic launch();
        for (int i = 0; i < N; i++) exp_b.push_back(b_ref[i]);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_send_end(input int already);
        int c = already;
        while (solver_in_en && c < N + 8) begin
            tick(1);
            c++;
        end
        checks++;
        if (c !== N || exp_b.size() !== 0) begin
            errors++;
            $display("FAIL send_len: in_en cycles=%0d left=%0d expected %0d left=0", c, exp_b.size(), N);
        end
    endtask

    task automatic feed(input int beats, input int extra);
        tick(LAT);
        for (int i = 0; i < beats + extra; i++) begin
            solver_out_valid = 1'b1;
            solver_x = i < beats ? x_drv[i] : 32'hBAD0_0000 + 32'(i);
            if (i < beats) x_prev[i] = x_drv[i];
            tick(1);
        end
        solver_out_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < TIMEOUT + 64) begin
            tick(1);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%b expected 1 after %0d cycles", done, cyc);
        end
    endtask

    task automatic check_xmem();
        for (int i = 0; i < N; i++) begin
            x_rd_addr = 4'(i);
            #1;
            checks++;
            if (x_rd_data !== x_prev[i]) begin
                errors++;
                $display("FAIL x_mem[%0d]: got %0h expected %0h", i, x_rd_data, x_prev[i]);
            end
        end
    endtask

    task automatic run(input int beats, input int extra, output int cyc);
        launch();
        wait_send_end(0);
        feed(beats, extra);
        wait_done(cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        checks++;
        if ({solver_in_en, busy, done, pass, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {solver_in_en, busy, done, pass, timeout});
        end
        checks++;
        if (solver_b !== 16'h0 || max_err !== 42'h0) begin
            errors++;
            $display("FAIL reset_data: solver_b=%0h max_err=%0h expected 0", solver_b, max_err);
        end
        check_xmem();
    endtask

    task automatic test_zero();
        int cyc;
        run(N, 0, cyc);
        checks++;
        if (pass !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_flags: pass=%b timeout=%b busy=%b expected 1 0 0", pass, timeout, busy);
        end
        checks++;
        if (max_err !== 42'h0) begin
            errors++;
            $display("FAIL zero_max: got %0d expected 0", max_err);
        end
        check_xmem();
    endtask

    task automatic test_ones();
        int cyc;
        load_ones();
        run(N, 0, cyc);
        checks++;
        if (pass !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL ones_flags: pass=%b timeout=%b expected 1 0", pass, timeout);
        end
        checks++;
        if (max_err !== 42'(model_max()) || max_err !== 42'h0) begin
            errors++;
            $display("FAIL ones_max: got %0d expected %0d", max_err, model_max());
        end
        check_xmem();
    endtask

    task automatic test_corrupt();
        int cyc;
        x_drv[5] = 32'sh0002_0000;
        run(N, 0, cyc);
        checks++;
        if (pass !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL corrupt_flags: pass=%b timeout=%b expected 0 0", pass, timeout);
        end
        checks++;
        if (max_err !== 42'd1310720 || max_err !== 42'(model_max())) begin
            errors++;
            $display("FAIL corrupt_max: got %0d expected 1310720 (model %0d)", max_err, model_max());
        end
        check_xmem();
        x_drv[5] = 32'sh0001_0000;
    endtask

    task automatic test_timeout();
        int cyc;
        launch();
        wait_send_end(0);
        feed(N - 1, 0);
        wait_done(cyc);
        checks++;
        if (LAT + N - 1 + cyc !== TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: done after %0d WAIT cycles expected %0d", LAT + N - 1 + cyc, TIMEOUT);
        end
        checks++;
        if (timeout !== 1'b1 || pass !== 1'b0 || max_err !== 42'h0) begin
            errors++;
            $display("FAIL timeout_flags: timeout=%b pass=%b max_err=%0d expected 1 0 0", timeout, pass, max_err);
        end
        check_xmem();
    endtask

    task automatic test_ignored();
        int cyc;
        launch();
        tick(3);
        start = 1'b1; b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 16'h7777;
        tick(1);
        start = 1'b0; b_wr_en = 1'b0;
        wait_send_end(4);
        feed(N, 3);
        wait_done(cyc);
        checks++;
        if (pass !== 1'b1 || timeout !== 1'b0 || max_err !== 42'h0) begin
            errors++;
            $display("FAIL ignored_flags: pass=%b timeout=%b max_err=%0d expected 1 0 0", pass, timeout, max_err);
        end
        check_xmem();
        launch();
        wait_send_end(0);
        feed(N, 0);
        wait_done(cyc);
        checks++;
        if (pass !== 1'b1 || max_err !== 42'h0) begin
            errors++;
            $display("FAIL b_persist: pass=%b max_err=%0d expected 1 0", pass, max_err);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        launch();
        tick(7);
        reset = 1'b1;
        tick(1);
        checks++;
        if ({solver_in_en, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: in_en/busy/done=%b expected 000", {solver_in_en, busy, done});
        end
        reset = 1'b0;
        exp_b.delete();
        for (int i = 0; i < N; i++) begin
            b_ref[i] = '0;
            x_drv[i] = '0;
            x_prev[i] = '0;
        end
        check_xmem();
        run(N, 0, cyc);
        checks++;
        if (pass !== 1'b1 || timeout !== 1'b0 || max_err !== 42'h0) begin
            errors++;
            $display("FAIL post_reset_run: pass=%b timeout=%b max_err=%0d expected 1 0 0", pass, timeout, max_err);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            b_ref[i] = '0;
            x_drv[i] = '0;
            x_prev[i] = '0;
        end
        test_reset();
        test_zero();
        test_ones();
        test_corrupt();
        test_timeout();
        test_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
